// File: rtl/dht_sensor_ctrl.sv
// dht_sensor_ctrl: single-wire DHT11/DHT22 reader with 1 us tick, timeouts, checksum and auto-periodic sampling.
module dht_sensor_ctrl #(
    parameter int CLK_HZ         = 100_000_000,
    parameter int START_LOW_US   = 18_000,
    parameter int BIT_THRESH_US  = 40,
    parameter int TIMEOUT_US     = 200,
    parameter int AUTO_PERIOD_MS = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_mode,
    inout  wire         dht_io,
    output logic        o_busy,
    output logic        o_valid,
    output logic        o_chk_err,
    output logic        o_timeout,
    output logic [39:0] o_raw,
    output logic [15:0] o_humid,
    output logic [15:0] o_temp
);
    localparam int DIV = CLK_HZ / 1_000_000;
    localparam int DW  = DIV > 1 ? $clog2(DIV) : 1;
    localparam int AP  = AUTO_PERIOD_MS > 0 ? AUTO_PERIOD_MS - 1 : 0;

    typedef enum logic [2:0] {IDLE, START, RELEASE, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, DONE} state_t;

    state_t        state;
    logic [DW-1:0] div;
    logic          tick;
    logic [9:0]    us_cnt;
    logic [15:0]   ms_cnt;
    logic          fire;
    logic [1:0]    sync;
    logic          s_io;
    logic          s_prev;
    logic [14:0]   cnt;
    logic [5:0]    bitc;
    logic [39:0]   frame;
    logic          mode;
    logic          oe;
    logic          wait_st;
    logic [7:0]    sum;
    logic [15:0]   mag;

    assign dht_io  = (oe && state == START) ? 1'b0 : 1'bz;
    assign s_io    = sync[1];
    assign fire    = (AUTO_PERIOD_MS > 0) && tick && us_cnt == 10'd999 && ms_cnt == 16'(AP);
    assign wait_st = state inside {RELEASE, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH};
    assign sum     = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
    assign mag     = {1'b0, frame[22:16], frame[15:8]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div    <= '0;
            tick   <= 1'b0;
            us_cnt <= '0;
            ms_cnt <= '0;
            sync   <= 2'b11;
            s_prev <= 1'b1;
        end else begin
            div    <= (div == DW'(DIV - 1)) ? '0 : div + 1'b1;
            tick   <= div == DW'(DIV - 1);
            sync   <= {sync[0], dht_io};
            s_prev <= s_io;
            if (tick) us_cnt <= (us_cnt == 10'd999) ? '0 : us_cnt + 1'b1;
            if (tick && us_cnt == 10'd999) ms_cnt <= (ms_cnt == 16'(AP)) ? '0 : ms_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bitc      <= '0;
            frame     <= '0;
            mode      <= 1'b0;
            oe        <= 1'b0;
            o_busy    <= 1'b0;
            o_valid   <= 1'b0;
            o_chk_err <= 1'b0;
            o_timeout <= 1'b0;
            o_raw     <= '0;
            o_humid   <= '0;
            o_temp    <= '0;
        end else begin
            o_valid <= 1'b0;
            if (tick) cnt <= cnt + 1'b1;
            if (wait_st && cnt == 15'(TIMEOUT_US)) begin
                o_timeout <= 1'b1;
                o_valid   <= 1'b1;
                o_busy    <= 1'b0;
                state     <= IDLE;
                cnt       <= '0;
            end else begin
                case (state)
                    IDLE: if (i_start || fire) begin
                        state     <= START;
                        cnt       <= '0;
                        o_busy    <= 1'b1;
                        oe        <= 1'b1;
                        mode      <= i_mode;
                        bitc      <= '0;
                        o_chk_err <= 1'b0;
                        o_timeout <= 1'b0;
                    end
                    START: if (cnt == 15'(START_LOW_US)) begin
                        state <= RELEASE;
                        cnt   <= '0;
                        oe    <= 1'b0;
                    end
                    // the synchroniser still shows the host's own low here, so wait for a real falling edge
                    RELEASE: if (s_prev && !s_io) begin
                        state <= RESP_LOW;
                        cnt   <= '0;
                    end
                    RESP_LOW: if (s_io) begin
                        state <= RESP_HIGH;
                        cnt   <= '0;
                    end
                    RESP_HIGH: if (!s_io) begin
                        state <= BIT_LOW;
                        cnt   <= '0;
                    end
                    BIT_LOW: if (s_io) begin
                        state <= BIT_HIGH;
                        cnt   <= '0;
                    end
                    BIT_HIGH: if (!s_io) begin
                        frame <= {frame[38:0], cnt > 15'(BIT_THRESH_US)};
                        bitc  <= bitc + 1'b1;
                        state <= (bitc == 6'd39) ? DONE : BIT_LOW;
                        cnt   <= '0;
                    end
                    DONE: begin
                        o_raw <= frame;
                        if (sum == frame[7:0]) begin
                            o_humid <= frame[39:24];
                            o_temp  <= !mode ? frame[23:8] : (frame[23] ? -mag : mag);
                        end else begin
                            o_chk_err <= 1'b1;
                        end
                        o_valid <= 1'b1;
                        o_busy  <= 1'b0;
                        state   <= IDLE;
                        cnt     <= '0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dht_sensor_ctrl.sv
// tb_dht_sensor_ctrl: directed bench with a behavioural sensor on a 4 MHz instance and an auto-trigger instance at 1 MHz.
module tb_dht_sensor_ctrl;
    logic clk = 1'b0, rst = 1'b0, i_start = 1'b0, i_mode = 1'b0, drv = 1'b0;
    logic rst_a = 1'b0, i_start_a = 1'b0;
    wire  dht_io, dht_io_a;
    logic o_busy, o_valid, o_chk_err, o_timeout;
    logic [39:0] o_raw;
    logic [15:0] o_humid, o_temp;
    logic o_busy_a, o_valid_a, o_chk_err_a, o_timeout_a;
    logic [39:0] o_raw_a;
    logic [15:0] o_humid_a, o_temp_a;
    int checks = 0, errors = 0;
    int vcnt = 0;
    logic valid_d = 1'b0, busy_after = 1'b1;
    logic [15:0] cap_h = '0, cap_t = '0;

    pullup (dht_io);
    pullup (dht_io_a);
    assign dht_io = drv ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    dht_sensor_ctrl #(.CLK_HZ(4_000_000), .START_LOW_US(20), .BIT_THRESH_US(40), .TIMEOUT_US(200), .AUTO_PERIOD_MS(0)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_mode(i_mode), .dht_io(dht_io),
        .o_busy(o_busy), .o_valid(o_valid), .o_chk_err(o_chk_err), .o_timeout(o_timeout),
        .o_raw(o_raw), .o_humid(o_humid), .o_temp(o_temp));

    dht_sensor_ctrl #(.CLK_HZ(1_000_000), .START_LOW_US(2500), .BIT_THRESH_US(40), .TIMEOUT_US(200), .AUTO_PERIOD_MS(2)) dut_a (
        .clk(clk), .rst(rst_a), .i_start(i_start_a), .i_mode(1'b0), .dht_io(dht_io_a),
        .o_busy(o_busy_a), .o_valid(o_valid_a), .o_chk_err(o_chk_err_a), .o_timeout(o_timeout_a),
        .o_raw(o_raw_a), .o_humid(o_humid_a), .o_temp(o_temp_a));

    always @(negedge clk) begin
        valid_d <= o_valid;
        if (o_valid) begin
            vcnt  <= vcnt + 1;
            cap_h <= o_humid;
            cap_t <= o_temp;
        end
        if (valid_d) busy_after <= o_busy;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic us(input int n);
        repeat (4 * n) @(negedge clk);
    endtask

    task automatic start(input logic m);
        @(negedge clk);
        i_mode  = m;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    // host low, then release; the sensor answers 20 us later with the standard preamble and 40 bits
    task automatic sensor(input logic [39:0] f, input int zus, input int ous);
        int k = 0;
        while (dht_io !== 1'b0 && k < 1000) begin @(negedge clk); k++; end
        while (dht_io !== 1'b1 && k < 1000) begin @(negedge clk); k++; end
        check("host_release", 64'(k < 1000), 64'd1);
        us(20);
        drv = 1'b1; us(80);
        drv = 1'b0; us(80);
        for (int i = 39; i >= 0; i--) begin
            drv = 1'b1; us(50);
            drv = 1'b0; us(f[i] ? ous : zus);
        end
        drv = 1'b1; us(50);
        drv = 1'b0; us(10);
    endtask

    initial begin
        int n, d, d1, r1, v0, k;
        logic seen;
        repeat (5) @(negedge clk);
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_raw", 64'(o_raw), 64'd0);
        check("rst_humid", 64'(o_humid), 64'd0);
        check("rst_temp", 64'(o_temp), 64'd0);
        check("rst_flags", 64'({o_chk_err, o_timeout}), 64'd0);
        check("rst_line", 64'(dht_io), 64'd1);
        rst = 1'b1;
        repeat (10) @(negedge clk);

        start(1'b0);
        check("start_busy", 64'(o_busy), 64'd1);
        check("start_drive", 64'(dht_io), 64'd0);
        sensor(40'h3700190555, 26, 70);
        check("f1_vcnt", 64'(vcnt), 64'd1);
        check("f1_humid", 64'(o_humid), 64'h3700);
        check("f1_temp", 64'(o_temp), 64'h1905);
        check("f1_raw", 64'(o_raw), 64'h3700190555);
        check("f1_flags", 64'({o_chk_err, o_timeout}), 64'd0);
        check("f1_cap_h", 64'(cap_h), 64'h3700);
        check("f1_busy_after", 64'(busy_after), 64'd0);
        check("f1_busy", 64'(o_busy), 64'd0);

        start(1'b0);
        sensor(40'h3700190556, 26, 70);
        check("f2_vcnt", 64'(vcnt), 64'd2);
        check("f2_chk", 64'(o_chk_err), 64'd1);
        check("f2_humid", 64'(o_humid), 64'h3700);
        check("f2_temp", 64'(o_temp), 64'h1905);
        check("f2_raw", 64'(o_raw), 64'h3700190556);

        // 40 us highs must read 0 and 42 us highs 1
        start(1'b1);
        sensor(40'h028C806573, 40, 42);
        check("f3_vcnt", 64'(vcnt), 64'd3);
        check("f3_chk", 64'(o_chk_err), 64'd0);
        check("f3_humid", 64'(o_humid), 64'h028C);
        check("f3_temp", 64'(o_temp), 64'hFF9B);
        check("f3_cap_t", 64'(cap_t), 64'hFF9B);
        check("f3_raw", 64'(o_raw), 64'h028C806573);

        start(1'b1);
        sensor(40'h028C0065F3, 26, 70);
        check("f4_temp", 64'(o_temp), 64'h0065);
        check("f4_chk", 64'(o_chk_err), 64'd0);

        start(1'b0);
        repeat (10) @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check("to_busy", 64'(o_busy), 64'd1);
        check("to_drive", 64'(dht_io), 64'd0);
        k = 0;
        while (dht_io !== 1'b1 && k < 1000) begin @(negedge clk); k++; end
        v0 = vcnt;
        n = 0;
        while (!o_valid && n < 2000) begin @(negedge clk); n++; end
        check("to_window", 64'(n >= 796 && n <= 812), 64'd1);
        check("to_flag", 64'(o_timeout), 64'd1);
        check("to_chk", 64'(o_chk_err), 64'd0);
        check("to_temp_held", 64'(o_temp), 64'h0065);
        @(negedge clk);
        check("to_vcnt", 64'(vcnt), 64'(v0 + 1));
        repeat (20) @(negedge clk);
        check("to_no_requeue", 64'(o_busy), 64'd0);

        start(1'b1);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_line", 64'(dht_io), 64'd1);
        check("mid_rst_busy", 64'(o_busy), 64'd0);
        check("mid_rst_outs", 64'({o_humid, o_temp}), 64'd0);
        check("mid_rst_raw", 64'(o_raw), 64'd0);
        check("mid_rst_flags", 64'({o_valid, o_chk_err, o_timeout}), 64'd0);
        v0 = vcnt;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_vcnt", 64'(vcnt), 64'(v0));
        check("post_rst_busy", 64'(o_busy), 64'd0);

        // auto instance: fires every 2000 clocks, a transaction lasts ~2700 so every other fire is dropped
        rst_a = 1'b1;
        n = 0;
        while (!o_busy_a && n < 3000) begin @(negedge clk); n++; end
        r1 = n;
        check("auto_first", 64'(n >= 1990 && n <= 2010), 64'd1);
        d = 0;
        while (o_busy_a && d < 4000) begin @(negedge clk); n++; d++; end
        d1 = d;
        check("auto_timeout", 64'(o_timeout_a), 64'd1);
        seen = 1'b0;
        while (n < r1 + 3999) begin
            @(negedge clk);
            n++;
            if (o_busy_a) seen = 1'b1;
        end
        check("auto_dropped", 64'(seen), 64'd0);
        i_start_a = 1'b1;
        @(negedge clk);
        i_start_a = 1'b0;
        check("auto_second", 64'(o_busy_a), 64'd1);
        d = 0;
        while (o_busy_a && d < 4000) begin @(negedge clk); d++; end
        check("auto_single_len", 64'(d), 64'(d1));
        seen = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (o_busy_a) seen = 1'b1;
        end
        check("auto_no_double", 64'(seen), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
